// File: rtl/balance_round_controller.sv
// Timed two-lever balance game: captures nivel on nivel_locked, then plays NUM_ROUNDS rounds.
// Optional SCORE_LEVEL_WEIGHT_EN: a win scores nivel+1 points instead of 1.
module balance_round_controller #(
  parameter int NUM_ROUNDS      = 5,
  parameter int COUNTDOWN_TICKS = 3000,
  parameter int ROUND_TICKS     = 10000,
  parameter int ROUND_STEP      = 2000,
  parameter int HOLD_TICKS      = 500,
  parameter int TOL_BASE        = 4096,
  parameter int RESULT_TICKS    = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        nivel_locked,
  input  logic [1:0]  nivel,
  input  logic [15:0] alavanca1,
  input  logic [15:0] alavanca2,
  output logic [2:0]  state,
  output logic        in_balance,
  output logic [15:0] time_left,
  output logic [3:0]  round_idx,
  output logic        round_won,
  output logic        round_lost,
  output logic [7:0]  score,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_RESULT    = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [15:0] COUNTDOWN_T = 16'(COUNTDOWN_TICKS);
  localparam logic [15:0] ROUND_T     = 16'(ROUND_TICKS);
  localparam logic [15:0] STEP_T      = 16'(ROUND_STEP);
  localparam logic [15:0] HOLD_T      = 16'(HOLD_TICKS);
  localparam logic [15:0] RESULT_T    = 16'(RESULT_TICKS);
  localparam logic [16:0] TOL0        = 17'(TOL_BASE);
  localparam logic [3:0]  LAST_ROUND  = 4'(NUM_ROUNDS - 1);

  state_t      state_q, state_d;
  logic [1:0]  nivel_q, nivel_d;
  logic [15:0] time_left_q, time_left_d;
  logic [3:0]  round_idx_q, round_idx_d;
  logic [7:0]  score_q, score_d;
  logic [15:0] hold_q, hold_d;
  logic        won_q, won_d;
  logic        lost_q, lost_d;
  logic        in_balance_q, in_balance_d;

  logic signed [16:0] diff;
  logic [16:0]        mag;
  logic [16:0]        tol;
  logic [15:0]        round_time;
  logic [15:0]        hold_inc;
  logic               win;
  logic [7:0]         points;
  logic [8:0]         score_sum;

  // Sign-extend to 17 bits so the difference and its magnitude never overflow.
  assign diff       = $signed({alavanca1[15], alavanca1}) - $signed({alavanca2[15], alavanca2});
  assign mag        = diff[16] ? $unsigned(-diff) : $unsigned(diff);
  assign tol        = TOL0 >> nivel_q;
  assign round_time = ROUND_T - STEP_T * {14'd0, nivel_q};
  assign hold_inc   = hold_q + 16'd1;
  assign win        = in_balance_q && (hold_inc == HOLD_T);

`ifdef SCORE_LEVEL_WEIGHT_EN
  assign points = {6'd0, nivel_q} + 8'd1;
`else
  assign points = 8'd1;
`endif

  assign score_sum = {1'b0, score_q} + {1'b0, points};

  always_comb begin
    state_d      = state_q;
    nivel_d      = nivel_q;
    time_left_d  = time_left_q;
    round_idx_d  = round_idx_q;
    score_d      = score_q;
    hold_d       = hold_q;
    won_d        = 1'b0;
    lost_d       = 1'b0;
    in_balance_d = (mag <= tol);

    case (state_q)
      S_IDLE: begin
        if (nivel_locked) begin
          nivel_d     = nivel;
          round_idx_d = 4'd0;
          score_d     = 8'd0;
          time_left_d = COUNTDOWN_T;
          state_d     = S_COUNTDOWN;
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (time_left_q == 16'd1) begin
            state_d     = S_PLAY;
            time_left_d = round_time;
            hold_d      = 16'd0;
          end else begin
            time_left_d = time_left_q - 16'd1;
          end
        end
      end
      S_PLAY: begin
        // A win on the final tick of the round beats the timeout.
        if (tick) begin
          if (win) begin
            won_d       = 1'b1;
            score_d     = score_sum[8] ? 8'hFF : score_sum[7:0];
            state_d     = S_RESULT;
            time_left_d = RESULT_T;
          end else if (time_left_q == 16'd1) begin
            lost_d      = 1'b1;
            state_d     = S_RESULT;
            time_left_d = RESULT_T;
          end else begin
            hold_d      = in_balance_q ? hold_inc : 16'd0;
            time_left_d = time_left_q - 16'd1;
          end
        end
      end
      S_RESULT: begin
        if (tick) begin
          if (time_left_q == 16'd1) begin
            if (round_idx_q == LAST_ROUND) begin
              state_d     = S_DONE;
              time_left_d = 16'd0;
            end else begin
              round_idx_d = round_idx_q + 4'd1;
              state_d     = S_COUNTDOWN;
              time_left_d = COUNTDOWN_T;
            end
          end else begin
            time_left_d = time_left_q - 16'd1;
          end
        end
      end
      S_DONE: begin
        time_left_d = 16'd0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      nivel_q      <= 2'd0;
      time_left_q  <= 16'd0;
      round_idx_q  <= 4'd0;
      score_q      <= 8'd0;
      hold_q       <= 16'd0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      in_balance_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nivel_q      <= nivel_d;
      time_left_q  <= time_left_d;
      round_idx_q  <= round_idx_d;
      score_q      <= score_d;
      hold_q       <= hold_d;
      won_q        <= won_d;
      lost_q       <= lost_d;
      in_balance_q <= in_balance_d;
    end
  end

  assign state      = state_q;
  assign in_balance = in_balance_q;
  assign time_left  = time_left_q;
  assign round_idx  = round_idx_q;
  assign round_won  = won_q;
  assign round_lost = lost_q;
  assign score      = score_q;
  assign game_over  = (state_q == S_DONE);

endmodule

// File: tb/tb_balance_round_controller.sv
// Bench for balance_round_controller: directed game scenarios plus random play,
// every cycle compared against a behavioural model of the game rules.
module tb_balance_round_controller;

  localparam int NUM_ROUNDS      = 2;
  localparam int COUNTDOWN_TICKS = 2;
  localparam int ROUND_TICKS     = 20;
  localparam int ROUND_STEP      = 4;
  localparam int HOLD_TICKS      = 4;
  localparam int TOL_BASE        = 64;
  localparam int RESULT_TICKS    = 2;
`ifdef SCORE_LEVEL_WEIGHT_EN
  localparam int EXP_TWO_WINS_N3 = 8;
`else
  localparam int EXP_TWO_WINS_N3 = 2;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        tick;
  logic        nivel_locked;
  logic [1:0]  nivel;
  logic [15:0] alavanca1;
  logic [15:0] alavanca2;
  logic [2:0]  state;
  logic        in_balance;
  logic [15:0] time_left;
  logic [3:0]  round_idx;
  logic        round_won;
  logic        round_lost;
  logic [7:0]  score;
  logic        game_over;

  always #5 clock = ~clock;

  balance_round_controller #(
    .NUM_ROUNDS(NUM_ROUNDS), .COUNTDOWN_TICKS(COUNTDOWN_TICKS), .ROUND_TICKS(ROUND_TICKS),
    .ROUND_STEP(ROUND_STEP), .HOLD_TICKS(HOLD_TICKS), .TOL_BASE(TOL_BASE),
    .RESULT_TICKS(RESULT_TICKS)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .nivel_locked(nivel_locked), .nivel(nivel),
    .alavanca1(alavanca1), .alavanca2(alavanca2), .state(state), .in_balance(in_balance),
    .time_left(time_left), .round_idx(round_idx), .round_won(round_won),
    .round_lost(round_lost), .score(score), .game_over(game_over)
  );

  int errors = 0;
  int checks = 0;

  // Reference model of the game, advanced once per clock edge.
  int m_state, m_tl, m_round, m_score, m_hold, m_nivel;
  bit m_inbal, m_won, m_lost;

  int mode = 0;     // 0 static levers, 2 toggling diff, 3 balance near timeout
  int tog_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int points_for(input int lvl);
`ifdef SCORE_LEVEL_WEIGHT_EN
    return lvl + 1;
`else
    return 1;
`endif
  endfunction

  task automatic model_step();
    int d;
    bit nb;
    if (reset) begin
      m_state = 0; m_tl = 0; m_round = 0; m_score = 0; m_hold = 0; m_nivel = 0;
      m_inbal = 0; m_won = 0; m_lost = 0;
      return;
    end
    d = int'($signed(alavanca1)) - int'($signed(alavanca2));
    if (d < 0) d = -d;
    nb = (d <= (TOL_BASE >> m_nivel));
    m_won = 0;
    m_lost = 0;
    case (m_state)
      0: if (nivel_locked) begin
        m_nivel = int'(nivel); m_round = 0; m_score = 0; m_tl = COUNTDOWN_TICKS; m_state = 1;
      end
      1: if (tick) begin
        if (m_tl == 1) begin
          m_state = 2; m_tl = ROUND_TICKS - m_nivel * ROUND_STEP; m_hold = 0;
        end else m_tl--;
      end
      2: if (tick) begin
        if (m_inbal && (m_hold + 1 == HOLD_TICKS)) begin
          m_won = 1;
          m_score = (m_score + points_for(m_nivel) > 255) ? 255 : m_score + points_for(m_nivel);
          m_state = 3; m_tl = RESULT_TICKS;
        end else if (m_tl == 1) begin
          m_lost = 1; m_state = 3; m_tl = RESULT_TICKS;
        end else begin
          m_hold = m_inbal ? m_hold + 1 : 0;
          m_tl--;
        end
      end
      3: if (tick) begin
        if (m_tl == 1) begin
          if (m_round == NUM_ROUNDS - 1) begin
            m_state = 4; m_tl = 0;
          end else begin
            m_round++; m_state = 1; m_tl = COUNTDOWN_TICKS;
          end
        end else m_tl--;
      end
      default: ;
    endcase
    m_inbal = nb;
  endtask

  task automatic compare_all();
    chk("m_state", 32'(state), 32'(m_state));
    chk("m_in_balance", 32'(in_balance), 32'(m_inbal));
    chk("m_time_left", 32'(time_left), 32'(m_tl));
    chk("m_round_idx", 32'(round_idx), 32'(m_round));
    chk("m_round_won", 32'(round_won), 32'(m_won));
    chk("m_round_lost", 32'(round_lost), 32'(m_lost));
    chk("m_score", 32'(score), 32'(m_score));
    chk("m_game_over", 32'(game_over), 32'(m_state == 4));
  endtask

  task automatic drive_hook();
    if (mode == 2) begin
      tog_cnt++;
      alavanca1 = 16'd100;
      alavanca2 = (((tog_cnt / 3) % 2) != 0) ? 16'd130 : 16'd110;
    end else if (mode == 3) begin
      alavanca1 = 16'd100;
      alavanca2 = (m_state == 2 && m_tl <= HOLD_TICKS + 1) ? 16'd100 : 16'd200;
    end
  endtask

  task automatic cycle();
    drive_hook();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic start_game(input logic [1:0] lvl, input logic [15:0] a1, input logic [15:0] a2);
    reset = 1'b1;
    nivel_locked = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    nivel = lvl;
    alavanca1 = a1;
    alavanca2 = a2;
    nivel_locked = 1'b1;
  endtask

  // Runs until a round result pulse, counting observed PLAY cycles.
  task automatic run_round(input string tag, input bit exp_won, input int exp_play);
    int play_n = 0;
    int guard = 0;
    while (!(round_won || round_lost) && guard < 200) begin
      if (state == 3'd2) play_n++;
      cycle();
      guard++;
    end
    chk({tag, "_no_timeout"}, 32'(guard < 200), 32'd1);
    chk({tag, "_won"}, 32'(round_won), 32'(exp_won));
    chk({tag, "_lost"}, 32'(round_lost), 32'(!exp_won));
    chk({tag, "_play_ticks"}, 32'(play_n), 32'(exp_play));
    cycle();
    chk({tag, "_pulse_clear"}, 32'(round_won | round_lost), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    tick = 1'b1;
    nivel_locked = 1'b0;
    nivel = 2'd0;
    alavanca1 = 16'd0;
    alavanca2 = 16'd0;

    // Reset held with no lock: everything zero.
    for (int i = 0; i < 10; i++) cycle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_time_left", 32'(time_left), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_flags", 32'({in_balance, round_won, round_lost, game_over}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_stays", 32'(state), 32'd0);

    // nivel 0, diff 20 within 64: win after 4 ticks.
    start_game(2'd0, 16'd100, 16'd120);
    run_round("win_n0", 1'b1, 4);
    chk("win_n0_score", 32'(score), 32'd1);

    // nivel 3, diff 20 beyond 8: timeout after 8 ticks; later nivel changes ignored.
    start_game(2'd3, 16'd100, 16'd120);
    cycle();
    nivel = 2'd0;
    run_round("lose_n3", 1'b0, 8);
    chk("lose_n3_score", 32'(score), 32'd0);

    // nivel 2, in-tolerance runs of only 3 ticks: loss at 12 ticks.
    start_game(2'd2, 16'd100, 16'd110);
    tog_cnt = 0;
    mode = 2;
    run_round("toggle_n2", 1'b0, 12);
    mode = 0;

    // Hold completes on the final round tick: win takes priority.
    start_game(2'd0, 16'd100, 16'd200);
    mode = 3;
    run_round("win_at_timeout", 1'b1, ROUND_TICKS);
    mode = 0;

    // Two wins at nivel 3 finishing the game, then reset from DONE.
    start_game(2'd3, 16'd100, 16'd104);
    run_round("game_r0", 1'b1, 4);
    run_round("game_r1", 1'b1, 4);
    for (int g = 0; g < 20 && state != 3'd4; g++) cycle();
    chk("done_state", 32'(state), 32'd4);
    chk("done_game_over", 32'(game_over), 32'd1);
    chk("done_score", 32'(score), 32'(EXP_TWO_WINS_N3));
    chk("done_round_idx", 32'(round_idx), 32'd1);
    chk("done_time_left", 32'(time_left), 32'd0);
    reset = 1'b1;
    cycle();
    chk("done_rst_state", 32'(state), 32'd0);
    chk("done_rst_score", 32'(score), 32'd0);
    chk("done_rst_game_over", 32'(game_over), 32'd0);
    chk("done_rst_round_idx", 32'(round_idx), 32'd0);
    reset = 1'b0;

    // Random play: sparse ticks, levers mostly close, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      tick = ($urandom_range(0, 3) != 0);
      nivel_locked = $urandom_range(0, 1) == 1;
      nivel = 2'($urandom_range(0, 3));
      alavanca1 = 16'($urandom);
      if ($urandom_range(0, 9) < 8)
        alavanca2 = alavanca1 + 16'($urandom_range(0, 40)) - 16'd20;
      else
        alavanca2 = 16'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
